// File: rtl/multicycle_datapath.sv
// rtl/multicycle_datapath.sv - accumulator datapath driven by multicycle control strobes
module multicycle_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             e,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    input  logic             done,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             ovf,
    output logic             illegal
);

    logic [WIDTH-1:0] r_acc;
    logic             r_acc_ovf;
    logic [WIDTH-1:0] r_result;
    logic             r_result_valid;
    logic             r_ovf;
    logic             r_illegal;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_alu_out;
    logic             w_carry;
    logic             w_ovf_next;

    assign w_sum = {1'b0, r_acc} + {1'b0, y};

    always_comb begin
        w_alu_out = r_acc << 1;
        w_carry   = r_acc[WIDTH-1];
        case ({s1, s2})
            2'b10: begin
                w_alu_out = w_sum[WIDTH-1:0];
                w_carry   = w_sum[WIDTH];
            end
            2'b01: begin
                w_alu_out = r_acc - y;
                w_carry   = (r_acc < y);
            end
            default: begin
                w_alu_out = r_acc << 1;
                w_carry   = r_acc[WIDTH-1];
            end
        endcase
    end

    assign w_ovf_next = r_acc_ovf | w_carry;

    // Single priority chain: reset, then enable, then load vs. ALU vs. illegal combo.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc          <= '0;
            r_acc_ovf      <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_ovf          <= 1'b0;
            r_illegal      <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_illegal      <= 1'b0;
            if (e) begin
                if (!s0) begin
                    r_acc     <= x;
                    r_acc_ovf <= 1'b0;
                    if (done) begin
                        r_result       <= x;
                        r_ovf          <= 1'b0;
                        r_result_valid <= 1'b1;
                    end
                end else if (s1 && s2) begin
                    r_illegal <= 1'b1;
                end else begin
                    r_acc     <= w_alu_out;
                    r_acc_ovf <= w_ovf_next;
                    if (done) begin
                        r_result       <= w_alu_out;
                        r_ovf          <= w_ovf_next;
                        r_result_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign ovf          = r_ovf;
    assign illegal      = r_illegal;

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb/tb_multicycle_datapath.sv - directed self-checking bench for multicycle_datapath
module tb_multicycle_datapath;

    logic       clock = 1'b0;
    logic       reset;
    logic       e, s0, s1, s2, done;
    logic [7:0] x, y;
    logic [7:0] result;
    logic       result_valid, ovf, illegal;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    multicycle_datapath #(.WIDTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .e            (e),
        .s0           (s0),
        .s1           (s1),
        .s2           (s2),
        .done         (done),
        .x            (x),
        .y            (y),
        .result       (result),
        .result_valid (result_valid),
        .ovf          (ovf),
        .illegal      (illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle's strobes on the falling edge; return #1 after the rising edge.
    task automatic step(input logic irst, input logic ie, input logic is0, input logic is1,
                        input logic is2, input logic idone, input logic [7:0] ix,
                        input logic [7:0] iy);
        @(negedge clock);
        reset = irst; e = ie; s0 = is0; s1 = is1; s2 = is2; done = idone; x = ix; y = iy;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'bx, 1'bx, 1'bx, 1'b0, 8'hxx, 8'hxx);
    endtask

    task automatic run_pass(input string tag, input logic [7:0] ix, input logic [7:0] iy,
                            input logic mode, input logic [7:0] exp_res, input logic exp_ovf);
        step(1'b0, 1'b1, 1'b0, 1'bx, 1'bx, 1'b0, ix, 8'hxx);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hxx, 8'hxx);
        check({tag, "_novalid_c"}, result_valid, 1'b0);
        step(1'b0, 1'b1, 1'b1, ~mode, mode, 1'b1, 8'hxx, iy);
        check({tag, "_valid"}, result_valid, 1'b1);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_ovf"}, ovf, exp_ovf);
        idle();
        check({tag, "_valid_drop"}, result_valid, 1'b0);
        check({tag, "_result_hold"}, result, exp_res);
        check({tag, "_ovf_hold"}, ovf, exp_ovf);
    endtask

    initial begin
        reset = 1'b1; e = 1'b0; s0 = 1'b0; s1 = 1'b0; s2 = 1'b0; done = 1'b0; x = '0; y = '0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        check("rst_result", result, 8'd0);
        check("rst_valid", result_valid, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        idle();

        run_pass("add_5_3", 8'd5, 8'd3, 1'b0, 8'd13, 1'b0);
        run_pass("sub_5_3", 8'd5, 8'd3, 1'b1, 8'd7, 1'b0);
        run_pass("sub_1_5", 8'd1, 8'd5, 1'b1, 8'd253, 1'b1);
        run_pass("add_200_100", 8'd200, 8'd100, 1'b0, 8'd244, 1'b1);
        run_pass("add_clear", 8'd5, 8'd3, 1'b0, 8'd13, 1'b0);

        // Reset during the C step of a pass.
        step(1'b0, 1'b1, 1'b0, 1'bx, 1'bx, 1'b0, 8'd7, 8'hxx);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hxx, 8'hxx);
        check("midrst_result", result, 8'd0);
        check("midrst_valid", result_valid, 1'b0);
        check("midrst_ovf", ovf, 1'b0);
        check("midrst_illegal", illegal, 1'b0);
        idle();
        check("midrst_no_valid", result_valid, 1'b0);
        run_pass("after_rst", 8'd2, 8'd1, 1'b0, 8'd5, 1'b0);

        // Illegal combination with done: no capture, accumulator holds 9.
        step(1'b0, 1'b1, 1'b0, 1'bx, 1'bx, 1'b0, 8'd9, 8'hxx);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hxx, 8'd40);
        check("ill_pulse", illegal, 1'b1);
        check("ill_novalid", result_valid, 1'b0);
        check("ill_result_hold", result, 8'd5);
        idle();
        check("ill_drop", illegal, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hxx, 8'hxx);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hxx, 8'd0);
        check("ill_acc_held", result, 8'd18);
        check("ill_acc_valid", result_valid, 1'b1);

        // done with e=0 is ignored.
        step(1'b0, 1'b0, 1'bx, 1'bx, 1'bx, 1'b1, 8'hxx, 8'hxx);
        check("done_no_e", result_valid, 1'b0);

        // Enabled steps separated by disabled cycles with X operands.
        step(1'b0, 1'b1, 1'b0, 1'bx, 1'bx, 1'b0, 8'd5, 8'hxx);
        idle();
        idle();
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hxx, 8'hxx);
        idle();
        check("gap_novalid", result_valid, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hxx, 8'd3);
        check("gap_valid", result_valid, 1'b1);
        check("gap_result", result, 8'd13);
        check("gap_ovf", ovf, 1'b0);

        // Load step carrying done captures the loaded operand.
        step(1'b0, 1'b1, 1'b0, 1'bx, 1'bx, 1'b1, 8'd77, 8'hxx);
        check("load_done_result", result, 8'd77);
        check("load_done_valid", result_valid, 1'b1);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Datapath stage directly downstream of the multicycle control-unit FSM. It consumes the FSM's `e`, `s0`, `s1`, `s2` and `done` strobes and executes one three-step operation per FSM pass: load X, double it, then add or subtract Y. The result is registered and reported with a one-cycle valid pulse and an overflow flag. The datapath contains no sequencing logic of its own; all ordering comes from the control strobes.

## Interface
- `WIDTH`, default 8: operand, accumulator and result width in bits.

- `clock`  in  1  single clock; everything updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `e`  in  1  accumulator write enable.
- `s0`  in  1  source select: 0 loads `x`, 1 loads the ALU output.
- `s1`  in  1  ALU add select; valid only when `e=1` and `s0=1`.
- `s2`  in  1  ALU subtract select; valid only when `e=1` and `s0=1`.
- `done`  in  1  final step of the operation; capture the result.
- `x`  in  WIDTH  first operand, sampled when `e=1` and `s0=0`.
- `y`  in  WIDTH  second operand, sampled on add and subtract steps.
- `result`  out  WIDTH  registered result of the last completed operation.
- `result_valid`  out  1  one-cycle pulse; `result` is new this cycle.
- `ovf`  out  1  overflow flag of the last completed operation; holds until the next capture.
- `illegal`  out  1  registered; high for one cycle after an illegal strobe combination.

## Operation
- Internal accumulator `acc[WIDTH-1:0]` and internal sticky flag `acc_ovf`.
- The ALU is combinational on `acc`, selected by {`s1`,`s2`}:
  - 00: shift left, `acc<<1`; carry-out is the old `acc[WIDTH-1]`.
  - 10: `acc+y`; carry-out is bit WIDTH of the sum.
  - 01: `acc-y`; carry-out is the borrow (`acc<y`, unsigned).
  - 11: illegal.
- All arithmetic is unsigned, modulo 2^WIDTH. No saturation.
- Per-cycle behaviour, evaluated in this priority order:
  1. `reset=1`: `acc`, `acc_ovf`, `result`, `result_valid`, `ovf`, `illegal` all go to 0.
  2. `e=0`: `acc` and `acc_ovf` hold. `s0`, `s1`, `s2`, `x`, `y` are ignored and may be X. `done` is ignored.
  3. `e=1`, `s0=0`:
     - `acc<=x`, `acc_ovf<=0`.
     - `s1`/`s2` are ignored and may be X.
  4. `e=1`, `s0=1`, {`s1`,`s2`}≠11:
     - `acc<=alu_out`.
     - `acc_ovf<=acc_ovf|carry`.
  5. `e=1`, `s0=1`, `s1=s2=1`:
     - `acc` and `acc_ovf` hold.
     - `illegal<=1` next cycle.
     - If `done` is also high, no capture occurs.
- Capture: when `done=1` and `e=1` and the step is legal:
  - `result` takes the value being written into `acc` on that edge.
  - `ovf` takes `acc_ovf|carry` (`acc_ovf` if the step is a load).
  - `result_valid<=1`.
- `done=1` with `e=0` is ignored; no capture.
- `result_valid` and `illegal` are 0 in every cycle not described above.
- Normal FSM pass (states A→B→C→D):
  - B: load `x`.
  - C: shift.
  - D: add (mode 0) or subtract (mode 1), with `done=1`.
  - Computes 2x+y or 2x−y mod 2^WIDTH.

## Timing
- Capture latency: `result`/`result_valid` appear the cycle after the D-state edge. That is 3 cycles after the first enabled step (the B state).
- `result` and `ovf` hold their value until the next capture or reset.
- `x` and `y` may change freely between steps. Each is sampled only on the edge of the step that uses it.
- Reset mid-operation:
  - Clears `acc` and `acc_ovf`; no `result_valid` is produced.
  - The next load restarts cleanly.
- Back-to-back passes: consecutive D→A→B sequences need no idle cycle beyond those the FSM already inserts.
- A load (`s0=0`) that arrives while a pass is in progress overrides the accumulator and clears the overflow state.

## Test plan
- WIDTH=8, x=5, y=3, mode 0 strobes B,C,D → `result=13`, `ovf=0`, `result_valid` high exactly 1 cycle after D.
- x=5, y=3, mode 1 → `result=7`, `ovf=0`. Then x=1, y=5, mode 1 → `result=253`, `ovf=1` (borrow).
- x=200, y=100, mode 0 → shift gives 144 with carry; `result=244`, `ovf=1`. A following pass x=5, y=3, mode 0 → `ovf=0` (flag cleared by the load).
- Assert `reset` in the C state of a pass → all outputs 0 next cycle and no `result_valid`. A new full pass x=2, y=1, mode 0 → `result=5`.
- Drive `e=1`, `s0=1`, `s1=s2=1`, `done=1` after loading x=9 → `illegal` pulses 1 cycle, `acc` holds 9, `result_valid` stays 0.
- Insert `e=0` cycles between steps, with X on `s0`, `s1`, `s2`, `x`, `y` during them → the result equals the uninterrupted pass.
